// File: rtl/ev_pkg.sv
// Shared types for the event timestamper and the UART event packer.
package ev_pkg;

  localparam int TS_W_DEF  = 64;
  localparam int ID_W_DEF  = 16;
  localparam int SLOTS_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // One completed event as handed to the packer.
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [TS_W_DEF-1:0] start_ts;
    logic [TS_W_DEF-1:0] end_ts;
    logic [TS_W_DEF-1:0] delta;
  } ev_rec_t;

endpackage

// File: rtl/ev_pending_table.sv
// Table of in-flight events: {valid, id, ts} per slot.
// The end lookup sees the table as it was before this cycle's start.
// The start then sees the table with that end's slot already freed.
module ev_pending_table
  import ev_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int PW    = $clog2(SLOTS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_stb_i,
  input  logic [ID_W-1:0] start_id_i,
  input  logic            end_stb_i,
  input  logic [ID_W-1:0] end_id_i,
  input  logic [TS_W-1:0] ts_i,
  output logic            end_hit_o,
  output logic [TS_W-1:0] end_ts_o,
  output logic            start_drop_o,
  output logic [PW-1:0]   pending_o
);

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [ID_W-1:0]  id_q [SLOTS];
  logic [ID_W-1:0]  id_d [SLOTS];
  logic [TS_W-1:0]  ts_q [SLOTS];
  logic [TS_W-1:0]  ts_d [SLOTS];

  logic [SLOTS-1:0] end_hit_vec;
  logic [SLOTS-1:0] valid_after_end;
  logic [SLOTS-1:0] start_hit_vec;
  logic [SLOTS-1:0] alloc_vec;
  logic             free_found;

  // Match ends against current entries, then place the start into the post-end table.
  always_comb begin
    end_hit_vec     = '0;
    start_hit_vec   = '0;
    alloc_vec       = '0;
    free_found      = 1'b0;
    end_ts_o        = '0;
    start_drop_o    = 1'b0;
    valid_d         = valid_q;
    id_d            = id_q;
    ts_d            = ts_q;

    for (int i = 0; i < SLOTS; i++) begin
      if (end_stb_i && valid_q[i] && (id_q[i] == end_id_i)) begin
        end_hit_vec[i] = 1'b1;
        end_ts_o       = end_ts_o | ts_q[i];
      end
    end
    end_hit_o       = |end_hit_vec;
    valid_after_end = valid_q & ~end_hit_vec;

    for (int i = 0; i < SLOTS; i++) begin
      if (valid_after_end[i] && (id_q[i] == start_id_i)) begin
        start_hit_vec[i] = 1'b1;
      end
      if (!valid_after_end[i] && !free_found) begin
        alloc_vec[i] = 1'b1;
        free_found   = 1'b1;
      end
    end

    valid_d = valid_after_end;
    if (start_stb_i) begin
      if (|start_hit_vec) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (start_hit_vec[i]) ts_d[i] = ts_i;
        end
      end else if (free_found) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (alloc_vec[i]) begin
            valid_d[i] = 1'b1;
            id_d[i]    = start_id_i;
            ts_d[i]    = ts_i;
          end
        end
      end else begin
        start_drop_o = 1'b1;
      end
    end
  end

  // Table storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        id_q[i] <= '0;
        ts_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  // Occupancy of the registered table.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < SLOTS; i++) begin
      pending_o = pending_o + PW'(valid_q[i]);
    end
  end

endmodule

// File: rtl/ev_timestamper.sv
// Stamps start/end strobes with a free-running counter and emits one
// {id, start, end, delta} record per completed event.
// Output handshake: ev_valid, once set, holds with ev_* stable until a cycle
// where ev_valid && ev_ready; a new record may load in that same cycle.
module ev_timestamper
  import ev_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int SLOTS = SLOTS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_stb,
  input  logic [ID_W-1:0]            start_id,
  input  logic                       end_stb,
  input  logic [ID_W-1:0]            end_id,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [ID_W-1:0]            ev_id,
  output logic [TS_W-1:0]            ev_start,
  output logic [TS_W-1:0]            ev_end,
  output logic [TS_W-1:0]            ev_delta,
  output logic [TS_W-1:0]            ts_now,
  output logic [$clog2(SLOTS+1)-1:0] pending,
  output logic [CNT_W-1:0]           drop_full,
  output logic [CNT_W-1:0]           drop_nomatch,
  output logic [CNT_W-1:0]           drop_busy
);

  logic [TS_W-1:0]  ts_q;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [TS_W-1:0]  start_q, start_d;
  logic [TS_W-1:0]  end_q, end_d;
  logic [TS_W-1:0]  delta_q, delta_d;
  logic [CNT_W-1:0] full_q, full_d;
  logic [CNT_W-1:0] nomatch_q, nomatch_d;
  logic [CNT_W-1:0] busy_q, busy_d;

  logic             end_hit;
  logic [TS_W-1:0]  end_ts;
  logic             start_drop;
  logic             out_free;

  ev_pending_table #(
    .SLOTS (SLOTS),
    .ID_W  (ID_W),
    .TS_W  (TS_W)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .start_stb_i  (start_stb),
    .start_id_i   (start_id),
    .end_stb_i    (end_stb),
    .end_id_i     (end_id),
    .ts_i         (ts_q),
    .end_hit_o    (end_hit),
    .end_ts_o     (end_ts),
    .start_drop_o (start_drop),
    .pending_o    (pending)
  );

  // Output register load/clear and saturating drop accounting.
  always_comb begin
    valid_d   = valid_q;
    id_d      = id_q;
    start_d   = start_q;
    end_d     = end_q;
    delta_d   = delta_q;
    full_d    = full_q;
    nomatch_d = nomatch_q;
    busy_d    = busy_q;
    out_free  = !valid_q || ev_ready;

    if (valid_q && ev_ready) valid_d = 1'b0;

    if (end_stb) begin
      if (!end_hit) begin
        if (nomatch_q != '1) nomatch_d = nomatch_q + CNT_W'(1);
      end else if (out_free) begin
        valid_d = 1'b1;
        id_d    = end_id;
        start_d = end_ts;
        end_d   = ts_q;
        delta_d = ts_q - end_ts;
      end else begin
        if (busy_q != '1) busy_d = busy_q + CNT_W'(1);
      end
    end

    if (start_drop && (full_q != '1)) full_d = full_q + CNT_W'(1);
  end

  // Counter, output record and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q      <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      start_q   <= '0;
      end_q     <= '0;
      delta_q   <= '0;
      full_q    <= '0;
      nomatch_q <= '0;
      busy_q    <= '0;
    end else begin
      ts_q      <= ts_q + TS_W'(1);
      valid_q   <= valid_d;
      id_q      <= id_d;
      start_q   <= start_d;
      end_q     <= end_d;
      delta_q   <= delta_d;
      full_q    <= full_d;
      nomatch_q <= nomatch_d;
      busy_q    <= busy_d;
    end
  end

  assign ts_now       = ts_q;
  assign ev_valid     = valid_q;
  assign ev_id        = id_q;
  assign ev_start     = start_q;
  assign ev_end       = end_q;
  assign ev_delta     = delta_q;
  assign drop_full    = full_q;
  assign drop_nomatch = nomatch_q;
  assign drop_busy    = busy_q;

endmodule

// File: tb/tb_ev_timestamper.sv
// Bench for ev_timestamper: default-width instance plus an 8-bit-counter,
// 2-bit-drop-counter instance for wrap and saturation.
module tb_ev_timestamper;

  localparam int TS_W  = 64;
  localparam int ID_W  = 16;
  localparam int SLOTS = 4;
  localparam int CNT_W = 16;
  localparam int PW    = 3;
  localparam int REC_W = ID_W + 3 * TS_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic             start_stb, end_stb, ev_ready;
  logic [ID_W-1:0]  start_id, end_id;
  logic             ev_valid;
  logic [ID_W-1:0]  ev_id;
  logic [TS_W-1:0]  ev_start, ev_end, ev_delta, ts_now;
  logic [PW-1:0]    pending;
  logic [CNT_W-1:0] drop_full, drop_nomatch, drop_busy;

  ev_timestamper #(.TS_W(TS_W), .ID_W(ID_W), .SLOTS(SLOTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .start_stb(start_stb), .start_id(start_id),
    .end_stb(end_stb), .end_id(end_id),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_id(ev_id), .ev_start(ev_start), .ev_end(ev_end), .ev_delta(ev_delta),
    .ts_now(ts_now), .pending(pending),
    .drop_full(drop_full), .drop_nomatch(drop_nomatch), .drop_busy(drop_busy)
  );

  // ---------------- narrow DUT ----------------
  logic             start_stb8, end_stb8, ev_ready8;
  logic [ID_W-1:0]  start_id8, end_id8;
  logic             ev_valid8;
  logic [ID_W-1:0]  ev_id8;
  logic [7:0]       ev_start8, ev_end8, ev_delta8, ts_now8;
  logic [PW-1:0]    pending8;
  logic [1:0]       drop_full8, drop_nomatch8, drop_busy8;

  ev_timestamper #(.TS_W(8), .ID_W(ID_W), .SLOTS(SLOTS), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst),
    .start_stb(start_stb8), .start_id(start_id8),
    .end_stb(end_stb8), .end_id(end_id8),
    .ev_valid(ev_valid8), .ev_ready(ev_ready8),
    .ev_id(ev_id8), .ev_start(ev_start8), .ev_end(ev_end8), .ev_delta(ev_delta8),
    .ts_now(ts_now8), .pending(pending8),
    .drop_full(drop_full8), .drop_nomatch(drop_nomatch8), .drop_busy(drop_busy8)
  );

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  // Every accepted record (valid && ready) must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      logic [REC_W-1:0] got, exp;
      got = {ev_id, ev_start, ev_end, ev_delta};
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_record got=%h expected=<none>", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL record got=%h expected=%h", got, exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] t);
    int n = 0;
    while (ts_now !== t && n < 400) begin
      step();
      n++;
    end
    if (ts_now !== t) begin
      checks++;
      failures++;
      $display("FAIL wait_ts got=%0d expected=%0d", ts_now, t);
    end
  endtask

  task automatic wait_ts8(input logic [7:0] t);
    int n = 0;
    while (ts_now8 !== t && n < 400) begin
      step();
      n++;
    end
    if (ts_now8 !== t) begin
      checks++;
      failures++;
      $display("FAIL wait_ts8 got=%0d expected=%0d", ts_now8, t);
    end
  endtask

  task automatic pulse(input logic s, input logic [ID_W-1:0] sid,
                       input logic e, input logic [ID_W-1:0] eid);
    start_stb = s;
    start_id  = sid;
    end_stb   = e;
    end_id    = eid;
    step();
    start_stb = 1'b0;
    end_stb   = 1'b0;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [TS_W-1:0] st,
                          input logic [TS_W-1:0] en);
    logic [TS_W-1:0] d;
    d = en - st;
    exp_q.push_back({id, st, en, d});
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained got=%0d expected=0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if ({ev_valid, pending, drop_full, drop_nomatch, drop_busy, ts_now} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b pend=%0d df=%0d dn=%0d db=%0d ts=%0d expected all 0",
               ev_valid, pending, drop_full, drop_nomatch, drop_busy, ts_now);
    end
    do_reset();
    repeat (5) step();
    checks++;
    if (ts_now !== 64'd5) begin
      failures++;
      $display("FAIL counter_run got=%0d expected=5", ts_now);
    end
  endtask

  task automatic test_single();
    do_reset();
    wait_ts(10);
    pulse(1'b1, 16'h0001, 1'b0, '0);
    checks++;
    if (pending !== 3'd1) begin
      failures++;
      $display("FAIL single_pending1 got=%0d expected=1", pending);
    end
    wait_ts(25);
    push_exp(16'h0001, 10, 25);
    pulse(1'b0, '0, 1'b1, 16'h0001);
    checks++;
    if (ev_valid !== 1'b1 || ev_end !== 64'd25 || pending !== 3'd0) begin
      failures++;
      $display("FAIL single_latency got valid=%b end=%0d pend=%0d expected 1/25/0",
               ev_valid, ev_end, pending);
    end
    step();
    checks++;
    if (ev_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_consumed got=%b expected=0", ev_valid);
    end
    check_drained("single");
  endtask

  task automatic test_table_full();
    int hs0;
    do_reset();
    wait_ts(10);
    for (int k = 0; k < 5; k++) pulse(1'b1, 16'h0010 + ID_W'(k), 1'b0, '0);
    checks++;
    if (pending !== 3'd4 || drop_full !== 16'd1) begin
      failures++;
      $display("FAIL full_state got pend=%0d drop_full=%0d expected 4/1", pending, drop_full);
    end
    wait_ts(20);
    hs0 = hs_count;
    push_exp(16'h0012, 12, 20);
    push_exp(16'h0010, 10, 21);
    push_exp(16'h0013, 13, 22);
    push_exp(16'h0011, 11, 23);
    pulse(1'b0, '0, 1'b1, 16'h0012);
    pulse(1'b0, '0, 1'b1, 16'h0010);
    pulse(1'b0, '0, 1'b1, 16'h0013);
    pulse(1'b0, '0, 1'b1, 16'h0011);
    step();
    checks++;
    if (pending !== 3'd0 || (hs_count - hs0) != 4) begin
      failures++;
      $display("FAIL full_drain got pend=%0d records=%0d expected 0/4", pending, hs_count - hs0);
    end
    check_drained("full");
  endtask

  task automatic test_backpressure();
    int hs0;
    logic [REC_W-1:0] held;
    do_reset();
    ev_ready = 1'b0;
    wait_ts(10);
    pulse(1'b1, 16'h0021, 1'b0, '0);
    pulse(1'b1, 16'h0022, 1'b0, '0);
    wait_ts(20);
    push_exp(16'h0021, 10, 20);
    pulse(1'b0, '0, 1'b1, 16'h0021);
    pulse(1'b0, '0, 1'b1, 16'h0022);
    for (int k = 0; k < 3; k++) begin
      held = {ev_id, ev_start, ev_end, ev_delta};
      checks++;
      if (ev_valid !== 1'b1 || held !== {16'h0021, 64'd10, 64'd20, 64'd10}) begin
        failures++;
        $display("FAIL bp_hold got valid=%b rec=%h expected record 0021/10/20/10", ev_valid, held);
      end
      step();
    end
    checks++;
    if (drop_busy !== 16'd1 || pending !== 3'd0) begin
      failures++;
      $display("FAIL bp_busy got busy=%0d pend=%0d expected 1/0", drop_busy, pending);
    end
    hs0 = hs_count;
    ev_ready = 1'b1;
    step();
    step();
    checks++;
    if (ev_valid !== 1'b0 || (hs_count - hs0) != 1) begin
      failures++;
      $display("FAIL bp_release got valid=%b records=%0d expected 0/1", ev_valid, hs_count - hs0);
    end
    check_drained("bp");
  endtask

  task automatic test_same_id();
    do_reset();
    wait_ts(100);
    pulse(1'b1, 16'h0007, 1'b0, '0);
    wait_ts(140);
    push_exp(16'h0007, 100, 140);
    pulse(1'b1, 16'h0007, 1'b1, 16'h0007);
    checks++;
    if (pending !== 3'd1 || ev_valid !== 1'b1 || ev_delta !== 64'd40) begin
      failures++;
      $display("FAIL same_id_first got pend=%0d valid=%b delta=%0d expected 1/1/40",
               pending, ev_valid, ev_delta);
    end
    wait_ts(150);
    push_exp(16'h0007, 140, 150);
    pulse(1'b0, '0, 1'b1, 16'h0007);
    checks++;
    if (pending !== 3'd0 || ev_delta !== 64'd10) begin
      failures++;
      $display("FAIL same_id_second got pend=%0d delta=%0d expected 0/10", pending, ev_delta);
    end
    step();
    check_drained("same_id");
  endtask

  task automatic test_nomatch_overwrite();
    do_reset();
    wait_ts(5);
    pulse(1'b1, 16'h0003, 1'b0, '0);
    wait_ts(8);
    pulse(1'b1, 16'h0003, 1'b0, '0);
    checks++;
    if (pending !== 3'd1) begin
      failures++;
      $display("FAIL overwrite_pending got=%0d expected=1", pending);
    end
    wait_ts(10);
    pulse(1'b0, '0, 1'b1, 16'h0009);
    checks++;
    if (drop_nomatch !== 16'd1 || ev_valid !== 1'b0) begin
      failures++;
      $display("FAIL nomatch got dn=%0d valid=%b expected 1/0", drop_nomatch, ev_valid);
    end
    wait_ts(20);
    push_exp(16'h0003, 8, 20);
    pulse(1'b0, '0, 1'b1, 16'h0003);
    checks++;
    if (ev_delta !== 64'd12) begin
      failures++;
      $display("FAIL overwrite_delta got=%0d expected=12", ev_delta);
    end
    step();
    check_drained("overwrite");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ev_ready = 1'b0;
    wait_ts(10);
    pulse(1'b1, 16'h0031, 1'b0, '0);
    pulse(1'b1, 16'h0032, 1'b0, '0);
    pulse(1'b1, 16'h0033, 1'b0, '0);
    pulse(1'b0, '0, 1'b1, 16'h0033);
    pulse(1'b0, '0, 1'b1, 16'h0099);
    checks++;
    if (pending !== 3'd2 || ev_valid !== 1'b1 || drop_nomatch !== 16'd1) begin
      failures++;
      $display("FAIL mid_setup got pend=%0d valid=%b dn=%0d expected 2/1/1",
               pending, ev_valid, drop_nomatch);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ev_valid, ev_id, ev_start, ev_end, ev_delta, ts_now} !== '0) begin
      failures++;
      $display("FAIL mid_reset_out got valid=%b id=%h st=%0d en=%0d d=%0d ts=%0d expected all 0",
               ev_valid, ev_id, ev_start, ev_end, ev_delta, ts_now);
    end
    checks++;
    if ({pending, drop_full, drop_nomatch, drop_busy} !== '0) begin
      failures++;
      $display("FAIL mid_reset_cnt got pend=%0d df=%0d dn=%0d db=%0d expected all 0",
               pending, drop_full, drop_nomatch, drop_busy);
    end
    step();
    rst = 1'b0;
    ev_ready = 1'b1;
    step();
    checks++;
    if (pending !== 3'd0 || ev_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_after got pend=%0d valid=%b expected 0/0", pending, ev_valid);
    end
    check_drained("mid");
  endtask

  task automatic test_wrap();
    do_reset();
    wait_ts8(8'd254);
    start_stb8 = 1'b1; start_id8 = 16'h0005;
    step();
    start_stb8 = 1'b0;
    wait_ts8(8'd2);
    end_stb8 = 1'b1; end_id8 = 16'h0005;
    step();
    end_stb8 = 1'b0;
    checks++;
    if (ev_valid8 !== 1'b1 || {ev_id8, ev_start8, ev_end8, ev_delta8} !== {16'h0005, 8'd254, 8'd2, 8'd4}) begin
      failures++;
      $display("FAIL wrap got valid=%b id=%h st=%0d en=%0d d=%0d expected 1/0005/254/2/4",
               ev_valid8, ev_id8, ev_start8, ev_end8, ev_delta8);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      end_stb8 = 1'b1;
      end_id8  = 16'h0055 + ID_W'($urandom_range(0, 3));
      step();
    end
    end_stb8 = 1'b0;
    checks++;
    if (drop_nomatch8 !== 2'd3) begin
      failures++;
      $display("FAIL saturate got=%0d expected=3", drop_nomatch8);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    start_stb = 1'b0; end_stb = 1'b0; start_id = '0; end_id = '0; ev_ready = 1'b1;
    start_stb8 = 1'b0; end_stb8 = 1'b0; start_id8 = '0; end_id8 = '0; ev_ready8 = 1'b1;
    test_reset();
    test_single();
    test_table_full();
    test_backpressure();
    test_same_id();
    test_nomatch_overwrite();
    test_reset_mid();
    test_wrap();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
